// File: rtl/bram_stream_loader.sv
// Round-robin port-A write feeder for a banked BRAM array, one stream word per cycle.
// Define LOADER_CLEAR_EN to zero the whole array before each frame is loaded.
module bram_stream_loader #(
  parameter int SIZE    = 32,
  parameter int WIDTH   = 16,
  parameter int ADDRESS = 10,
  parameter int CNT_W   = ADDRESS + $clog2(SIZE) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDRESS-1:0] base_addr,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               s_last,
  output logic [SIZE-1:0]    wea,
  output logic [SIZE-1:0]    ena,
  output logic [ADDRESS-1:0] addra [0:SIZE-1],
  output logic [WIDTH-1:0]   dina  [0:SIZE-1],
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   words_loaded,
  output logic               ovf
);

  localparam int BANK_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SIZE * (1 << ADDRESS));
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(SIZE - 1);

`ifdef LOADER_CLEAR_EN
  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;
  logic [ADDRESS-1:0] clr_cnt;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t             state, state_nxt;
  logic [ADDRESS-1:0] base_lat;
  logic [ADDRESS-1:0] row_off;
  logic [BANK_W-1:0]  bank_ptr;
  logic               acc_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign acc_p0 = s_valid & s_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef LOADER_CLEAR_EN
          state_nxt = CLEAR;
`else
          state_nxt = LOAD;
`endif
        end
      end
`ifdef LOADER_CLEAR_EN
      CLEAR:   if (&clr_cnt) state_nxt = LOAD;
`endif
      LOAD:    if (acc_p0 && s_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> lane registers: an accepted word is presented to its bank one cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ovf          <= 1'b0;
      words_loaded <= '0;
      base_lat     <= '0;
      row_off      <= '0;
      bank_ptr     <= '0;
      wea          <= '0;
      ena          <= '0;
      for (int i = 0; i < SIZE; i++) begin
        addra[i] <= '0;
        dina[i]  <= '0;
      end
`ifdef LOADER_CLEAR_EN
      clr_cnt      <= '0;
`endif
    end else begin
      s_ready <= (state_nxt == LOAD);
      done    <= (state == DONE);
      wea     <= '0;
      ena     <= '0;

      if (state == IDLE && start) begin
        base_lat     <= base_addr;
        words_loaded <= '0;
        ovf          <= 1'b0;
        busy         <= 1'b1;
        row_off      <= '0;
        bank_ptr     <= '0;
`ifdef LOADER_CLEAR_EN
        clr_cnt      <= '0;
`endif
      end else if (done) begin
        busy <= 1'b0;
      end

`ifdef LOADER_CLEAR_EN
      if (state == CLEAR) begin
        wea <= '1;
        ena <= '1;
        for (int i = 0; i < SIZE; i++) begin
          addra[i] <= clr_cnt;
          dina[i]  <= '0;
        end
        clr_cnt <= clr_cnt + 1'b1;
      end
`endif

      if (acc_p0) begin
        wea[bank_ptr]   <= 1'b1;
        ena[bank_ptr]   <= 1'b1;
        addra[bank_ptr] <= base_lat + row_off;
        dina[bank_ptr]  <= s_data;
        words_loaded    <= sat_inc(words_loaded);
        // The counter still holds k here, so this fires on the first word past a full array.
        if (words_loaded == FULL_CNT) ovf <= 1'b1;
        if (bank_ptr == LAST_BANK) begin
          bank_ptr <= '0;
          row_off  <= row_off + 1'b1;
        end else begin
          bank_ptr <= bank_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_loader.sv
// Directed bench for bram_stream_loader: scoreboard of expected lane writes plus a model of the array.
module tb_bram_stream_loader;

  localparam int SIZE    = 4;
  localparam int WIDTH   = 16;
  localparam int ADDRESS = 4;
  localparam int CNT_W   = ADDRESS + $clog2(SIZE) + 1;
  localparam int DEPTH   = 1 << ADDRESS;
  localparam int BW      = $clog2(SIZE);
  localparam int EW      = BW + ADDRESS + WIDTH;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [ADDRESS-1:0] base_addr = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [WIDTH-1:0]   s_data = '0;
  logic               s_last = 1'b0;
  logic [SIZE-1:0]    wea;
  logic [SIZE-1:0]    ena;
  logic [ADDRESS-1:0] addra [0:SIZE-1];
  logic [WIDTH-1:0]   dina  [0:SIZE-1];
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   words_loaded;
  logic               ovf;

  bram_stream_loader #(.SIZE(SIZE), .WIDTH(WIDTH), .ADDRESS(ADDRESS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .wea(wea), .ena(ena), .addra(addra), .dina(dina),
    .busy(busy), .done(done), .words_loaded(words_loaded), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k_idx = 0;
  int cur_base = 0;
  logic clear_mode = 1'b0;
  logic [WIDTH-1:0] mem [SIZE][DEPTH];
  logic [EW-1:0] sb_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Array model and scoreboard consumer: strobes seen at negedge are written at the next posedge.
  always @(negedge clk) begin
    int nact;
    logic [EW-1:0] exp_e;
    nact = 0;
    if (rst) begin
      for (int b = 0; b < SIZE; b++) if (wea[b]) nact++;
      if (wea != '0 || ena != '0) check("ena_eq_wea", ena, wea);
      if (clear_mode) begin
        for (int b = 0; b < SIZE; b++) if (wea[b]) mem[b][addra[b]] = dina[b];
      end else if (nact != 0) begin
        check("one_lane", nact, 1);
        for (int b = 0; b < SIZE; b++) begin
          if (wea[b]) begin
            mem[b][addra[b]] = dina[b];
            check("sb_pending", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
              exp_e = sb_q.pop_front();
              check("lane_write", {BW'(b), addra[b], dina[b]}, exp_e);
            end
          end
        end
      end
    end
  end

  task automatic do_start(input logic [ADDRESS-1:0] b);
    int n;
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
`ifdef LOADER_CLEAR_EN
    clear_mode = 1'b1;
`endif
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
`ifdef LOADER_CLEAR_EN
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("clear_to_load", s_ready, 1);
    @(negedge clk);
    clear_mode = 1'b0;
`else
    n = 0;
    check("ready_after_start", s_ready, 1);
`endif
    k_idx = 0;
    cur_base = int'(b);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d, input logic last);
    int n;
    logic [BW-1:0] eb;
    logic [ADDRESS-1:0] ea;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      check("ready_wait", s_ready, 1);
    end else begin
      eb = BW'(k_idx % SIZE);
      ea = ADDRESS'((cur_base + k_idx / SIZE) % DEPTH);
      sb_q.push_back({eb, ea, d});
      k_idx++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic finish_frame();
    check("ready_in_done", s_ready, 0);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_with_done", busy, 1);
    @(negedge clk);
    check("done_clear", done, 0);
    check("busy_clear", busy, 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    int bad;
    logic ok;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_words", words_loaded, 0);
    check("rst_wea", wea, 0);
    check("rst_ena", ena, 0);
    check("rst_addra", addra[0], 0);
    check("rst_dina", dina[SIZE-1], 0);
    rst = 1'b1;

    // Basic frame
    do_start(4'd2);
    for (int k = 0; k < 8; k++) send_word(16'h0100 + 16'(k), k == 7);
    finish_frame();
    check("basic_words", words_loaded, 8);
    check("basic_ovf", ovf, 0);
    check("basic_b0a2", mem[0][2], 16'h0100);
    check("basic_b0a3", mem[0][3], 16'h0104);
    check("basic_b3a3", mem[3][3], 16'h0107);

    // Reset mid-frame
    do_start(4'd5);
    for (int k = 0; k < 3; k++) send_word(16'h0A00 + 16'(k), 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_s_ready", s_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_words", words_loaded, 0);
    check("mrst_wea", wea, 0);
    bad = 0;
    for (int b = 0; b < SIZE; b++) if (addra[b] !== '0 || dina[b] !== '0) bad++;
    check("mrst_lanes", bad, 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    do_start(4'd0);
    send_word(16'hAAAA, 1'b1);
    finish_frame();
    check("mrst_reload", mem[0][0], 16'hAAAA);
    check("mrst_words1", words_loaded, 1);

    // Gap-free then gapped run of the same frame
    do_start(4'd6);
    for (int k = 0; k < 10; k++) send_word(16'h0300 + 16'(k), k == 9);
    finish_frame();
    for (int k = 0; k < 10; k++) check("nogap_mem", mem[k % SIZE][6 + k / SIZE], 16'h0300 + 16'(k));
    for (int k = 0; k < 10; k++) mem[k % SIZE][6 + k / SIZE] = 'x;
    do_start(4'd6);
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(16'h0300 + 16'(k), k == 9);
    end
    finish_frame();
    for (int k = 0; k < 10; k++) check("gap_mem", mem[k % SIZE][6 + k / SIZE], 16'h0300 + 16'(k));
    check("gap_words", words_loaded, 10);

    // Address wrap and overflow
    do_start(4'd15);
    for (int k = 0; k < 65; k++) begin
      send_word(16'h1000 + 16'(k), k == 64);
      if (k == 63) check("ovf_before", ovf, 0);
      if (k == 64) check("ovf_on_64", ovf, 1);
    end
    finish_frame();
    check("ovf_sticky", ovf, 1);
    check("wrap_words", words_loaded, 65);
    check("wrap_word4", mem[0][0], 16'h1004);
    check("ovf_word64", mem[0][15], 16'h1040);

    // Start ignored while busy
    do_start(4'd3);
    check("ovf_cleared", ovf, 0);
    for (int k = 0; k < 2; k++) send_word(16'h2000 + 16'(k), 1'b0);
    start = 1'b1;
    base_addr = 4'd9;
    @(negedge clk);
    start = 1'b0;
    check("ign_ready", s_ready, 1);
    check("ign_busy", busy, 1);
    check("ign_words", words_loaded, 2);
    for (int k = 2; k < 4; k++) send_word(16'h2000 + 16'(k), k == 3);
    finish_frame();
    check("ign_words_end", words_loaded, 4);
    check("ign_b2a3", mem[2][3], 16'h2002);
    check("ign_b3a3", mem[3][3], 16'h2003);

`ifdef LOADER_CLEAR_EN
    // Preload with all ones, then a clearing start
    do_start(4'd0);
    for (int k = 0; k < SIZE * DEPTH; k++) send_word(16'hFFFF, k == SIZE * DEPTH - 1);
    finish_frame();
    @(negedge clk);
    start = 1'b1;
    base_addr = 4'd0;
    clear_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("clr_first_idle", wea, 0);
    check("clr_ready0", s_ready, 0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      ok = (wea == '1) && (ena == '1);
      for (int b = 0; b < SIZE; b++) ok = ok && (addra[b] == ADDRESS'(i)) && (dina[b] == '0);
      check("clr_row", ok, 1);
      check("clr_ready", s_ready, i == DEPTH - 1);
      check("clr_busy", busy, 1);
    end
    @(negedge clk);
    clear_mode = 1'b0;
    k_idx = 0;
    cur_base = 0;
    for (int k = 0; k < 3; k++) send_word(16'h3000 + 16'(k), k == 2);
    finish_frame();
    bad = 0;
    for (int b = 0; b < SIZE; b++)
      for (int a = 0; a < DEPTH; a++)
        if (mem[b][a] !== ((a == 0 && b < 3) ? 16'h3000 + 16'(b) : 16'h0000)) bad++;
    check("clr_array", bad, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_stream_loader.md
# bram_stream_loader

Write-side feeder for the banked feature-map BRAM array. Accepts a single valid/ready stream of WIDTH-bit words and distributes consecutive words round-robin across SIZE banks through each bank's port A. Each bank's address advances once per full stripe. Port B of the array is left to the downstream consumer. Signals busy and done around each frame so the compute engine knows when the array holds a complete tile.

## Interface
- SIZE, 32, number of banks driven (one wea/ena/addra/dina lane per bank)
- WIDTH, 16, data word width
- ADDRESS, 10, per-bank address width; bank depth 2**ADDRESS
- CNT_W, ADDRESS+$clog2(SIZE)+1, width of the frame word counter

Ports:
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle frame start request; honoured only in IDLE
- base_addr  in  ADDRESS  per-bank start address, sampled on accepted start
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  WIDTH  stream word
- s_last  in  1  marks final word of frame
- wea  out  SIZE  per-bank write enable to port A
- ena  out  SIZE  per-bank enable to port A
- addra  out  ADDRESS x [0:SIZE-1]  per-bank port A address
- dina  out  WIDTH x [0:SIZE-1]  per-bank port A write data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last write is issued
- words_loaded  out  CNT_W  words accepted in current/last frame
- ovf  out  1  sticky: frame exceeded SIZE*2**ADDRESS words

## Operation
- States: IDLE, CLEAR (only with macro), LOAD, DONE.
- IDLE:
  - Outputs idle.
  - start=1 latches base_addr, clears words_loaded and ovf, sets busy.
  - Goes to CLEAR (macro on) or LOAD (macro off).
- LOAD:
  - s_ready=1. On s_valid&s_ready, word k of the frame (k from 0) is written to bank b = k mod SIZE at address (base_addr + k/SIZE) mod 2**ADDRESS.
  - Bank pointer wraps SIZE-1 -> 0; the row offset increments on that wrap.
  - The address wraps modulo 2**ADDRESS with no error.
  - words_loaded increments per accepted word and saturates at all-ones.
- Overflow:
  - On the accepted word with k = SIZE*2**ADDRESS, ovf sets and stays set until the next accepted start.
  - Writes continue with the wrapped address.
- Frame end: an accepted word with s_last=1 moves to DONE.
- DONE: lasts one cycle. done=1, busy=0 on the cycle after, then back to IDLE. s_ready=0.
- start is ignored outside IDLE.
- s_valid outside LOAD is ignored. No word is lost, because s_ready=0.
- Exactly one bank lane is active per accepted word. All other lanes have wea=ena=0, and their addra/dina hold their previous values.
- Reset (rst=0, any time, including mid-frame or mid-clear):
  - State goes to IDLE.
  - wea, ena, s_ready, busy, done, ovf, words_loaded = 0.
  - addra, dina entries = 0. Bank pointer and row offset = 0.
  - The partial frame is abandoned; the array keeps whatever was written.

## Timing
- s_ready is a registered state decode: 1 exactly in LOAD (and CLEAR never).
- A word accepted at edge n appears on wea/ena/addra/dina after edge n, so the array write happens at edge n+1.
- Sustained throughput is 1 word/cycle in LOAD.
- Start accepted at edge n: busy=1 after edge n. s_ready=1 after edge n (macro off) or after edge n+2**ADDRESS (macro on).
- Last word accepted at edge m: its write strobes are visible after m. done=1 and busy=1 after m+1. busy=0 and done=0 after m+2.
- Simultaneous start and reset: reset wins.

## Configuration
- LOADER_CLEAR_EN defined:
  - CLEAR runs for exactly 2**ADDRESS cycles.
  - All SIZE lanes have ena=wea=all ones and dina=0, with addra = 0,1,...,2**ADDRESS-1 on every lane.
  - The whole array is zeroed, then the block enters LOAD.
  - busy=1 and s_ready=0 throughout CLEAR.
- Not defined: the CLEAR state and its counter are not compiled. start goes directly to LOAD and untouched locations keep stale data.

## Test plan
All cases use SIZE=4, WIDTH=16, ADDRESS=4 unless noted.
- Reset mid-frame: assert rst low after 3 words -> all outputs 0 on the next sample. After release, start with base 0 reloads from bank 0, address 0.
- Basic frame: start with base_addr=2, then 8 words 0x0100..0x0107 with last on the 8th -> bank0 gets 0x0100@2 and 0x0104@3, bank3 gets 0x0107@3. words_loaded=8, one done pulse, ovf=0.
- Backpressure/gaps: random s_valid gaps over 10 words -> identical array contents to the gap-free run. No write strobe on any idle cycle.
- Wrap and overflow: base_addr=15, 65 words -> word 4 lands at address 0. ovf sets exactly on word 64, which writes bank0@15.
- Start ignored while busy: pulse start during LOAD -> no change to base, counters, or state.
- With LOADER_CLEAR_EN: preload array with 0xFFFF, start -> 16 clear cycles with s_ready=0, every location reads 0 afterwards except the loaded words.
